// File: rtl/crc_pkg.sv
// Shared types, preset CRC configurations and the bit-reflection helper.
package crc_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] poly;
        logic [31:0] init;
        logic [31:0] xor_out;
        logic        refin;
        logic        refout;
        logic [31:0] residue;
    } crc_preset_t;

    // Residues are the un-reflected register value seen after a good frame.
    localparam crc_preset_t CRC16_MODBUS = '{
        poly: 32'h0000_8005, init: 32'h0000_FFFF, xor_out: 32'h0000_0000,
        refin: 1'b1, refout: 1'b1, residue: 32'h0000_0000};
    localparam crc_preset_t CRC16_CCITT_FALSE = '{
        poly: 32'h0000_1021, init: 32'h0000_FFFF, xor_out: 32'h0000_0000,
        refin: 1'b0, refout: 1'b0, residue: 32'h0000_0000};
    localparam crc_preset_t CRC32 = '{
        poly: 32'h04C1_1DB7, init: 32'hFFFF_FFFF, xor_out: 32'hFFFF_FFFF,
        refin: 1'b1, refout: 1'b1, residue: 32'hC704_DD7B};

    function automatic logic [31:0] reflect(input logic [31:0] value, input int width);
        logic [31:0] r;
        r = 32'h0000_0000;
        for (int i = 0; i < 32; i++) begin
            if (i < width) r[i] = value[width-1-i];
            else           r[i] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_step.sv
// Combinational BPC-bit unrolled CRC update; in reflected mode the register is
// held bit-reversed and shifts right with the reflected polynomial.
module crc_step
    import crc_pkg::*;
#(
    parameter int               CRC_W      = 16,
    parameter logic [CRC_W-1:0] POLY       = 16'h8005,
    parameter int               BPC        = 8,
    parameter bit               REFLECT_IN = 1'b1
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic [BPC-1:0]   data,
    output logic [CRC_W-1:0] crc_out
);

    localparam logic [31:0]      POLY32 = 32'(POLY);
    localparam logic [CRC_W-1:0] RPOLY  = CRC_W'(reflect(POLY32, CRC_W));

    // Feed BPC data bits through the LFSR, oldest bit first.
    always_comb begin
        logic [CRC_W-1:0] acc;
        logic             fb;
        acc = crc_in;
        fb  = 1'b0;
        for (int i = 0; i < BPC; i++) begin
            if (REFLECT_IN) begin
                fb  = acc[0] ^ data[i];
                acc = (acc >> 1) ^ (fb ? RPOLY : {CRC_W{1'b0}});
            end else begin
                fb  = acc[CRC_W-1] ^ data[BPC-1-i];
                acc = (acc << 1) ^ (fb ? POLY : {CRC_W{1'b0}});
            end
        end
        crc_out = acc;
    end

endmodule

// File: rtl/crc_stream.sv
// Streaming CRC engine: accepts DATA_W-bit words, digests BPC bits per clock
// and reports the final CRC plus a residue check at the end of each frame.
module crc_stream
    import crc_pkg::*;
#(
    parameter int               CRC_W       = 16,
    parameter logic [CRC_W-1:0] POLY        = 16'h8005,
    parameter logic [CRC_W-1:0] INIT        = 16'hFFFF,
    parameter logic [CRC_W-1:0] XOR_OUT     = 16'h0000,
    parameter bit               REFLECT_IN  = 1'b1,
    parameter bit               REFLECT_OUT = 1'b1,
    parameter logic [CRC_W-1:0] RESIDUE     = 16'h0000,
    parameter int               DATA_W      = 8,
    parameter int               BPC         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              in_eof,
    output logic              out_valid,
    output logic [CRC_W-1:0]  out_crc,
    output logic              out_ok
);

    localparam int NSLICE = DATA_W / BPC;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CRC_W-1:0] INIT_I =
        REFLECT_IN ? CRC_W'(reflect(32'(INIT), CRC_W)) : INIT;

    generate
        if ((DATA_W % BPC) != 0 || CRC_W < 8 || CRC_W > 32) begin : g_param_err
            $error("crc_stream: BPC must divide DATA_W and CRC_W must be 8..32");
        end
    endgenerate

    state_t             state_r;
    logic [CRC_W-1:0]   crc_r;
    logic [DATA_W-1:0]  data_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               eof_r;
    logic               ready_r;
    logic               out_valid_r;
    logic [CRC_W-1:0]   out_crc_r;
    logic               out_ok_r;

    logic               xfer_s;
    logic [CRC_W-1:0]   step_crc_s;
    logic [BPC-1:0]     step_data_s;
    logic [CRC_W-1:0]   step_out_s;
    logic [CRC_W-1:0]   norm_s;
    logic [CRC_W-1:0]   report_s;
    logic               frame_end_s;

    // The slice consumed next sits at the end the bit order starts from.
    function automatic logic [BPC-1:0] slice_of(input logic [DATA_W-1:0] w);
        if (REFLECT_IN) return w[BPC-1:0];
        else            return w[DATA_W-1 -: BPC];
    endfunction

    function automatic logic [DATA_W-1:0] next_of(input logic [DATA_W-1:0] w);
        if (REFLECT_IN) return w >> BPC;
        else            return w << BPC;
    endfunction

    assign xfer_s = in_valid && ready_r;

    // Select the register and data slice fed to the update network.
    always_comb begin
        step_crc_s  = crc_r;
        step_data_s = slice_of(data_r);
        if (state_r == ST_IDLE) begin
            step_crc_s  = in_sof ? INIT_I : crc_r;
            step_data_s = slice_of(in_data);
        end else begin
            step_crc_s  = crc_r;
            step_data_s = slice_of(data_r);
        end
    end

    crc_step #(
        .CRC_W      (CRC_W),
        .POLY       (POLY),
        .BPC        (BPC),
        .REFLECT_IN (REFLECT_IN)
    ) u_step (
        .crc_in  (step_crc_s),
        .data    (step_data_s),
        .crc_out (step_out_s)
    );

    // Result formatting: undo the internal reflection, then apply output options.
    always_comb begin
        norm_s   = REFLECT_IN ? CRC_W'(reflect(32'(step_out_s), CRC_W)) : step_out_s;
        report_s = (REFLECT_OUT ? CRC_W'(reflect(32'(norm_s), CRC_W)) : norm_s) ^ XOR_OUT;
        if (state_r == ST_IDLE) begin
            frame_end_s = xfer_s && in_eof && (NSLICE == 1);
        end else begin
            frame_end_s = eof_r && (cnt_r == {CNT_W{1'b0}});
        end
    end

    // Control FSM, CRC register and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            crc_r       <= INIT_I;
            data_r      <= {DATA_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            eof_r       <= 1'b0;
            ready_r     <= 1'b1;
            out_valid_r <= 1'b0;
            out_crc_r   <= {CRC_W{1'b0}};
            out_ok_r    <= 1'b0;
        end else begin
            out_valid_r <= frame_end_s;
            if (frame_end_s) begin
                out_crc_r <= report_s;
                out_ok_r  <= (norm_s == RESIDUE);
            end
            case (state_r)
                ST_IDLE: begin
                    if (xfer_s) begin
                        crc_r  <= step_out_s;
                        data_r <= next_of(in_data);
                        eof_r  <= in_eof;
                        if (NSLICE > 1) begin
                            state_r <= ST_SHIFT;
                            ready_r <= 1'b0;
                            cnt_r   <= CNT_W'(NSLICE - 2);
                        end
                    end
                end
                ST_SHIFT: begin
                    crc_r  <= step_out_s;
                    data_r <= next_of(data_r);
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_IDLE;
                        ready_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = ready_r;
    assign out_valid = out_valid_r;
    assign out_crc   = out_crc_r;
    assign out_ok    = out_ok_r;

endmodule
